// File: rtl/gin_pkg.sv
// Shared definitions for the global input network: element/tag widths,
// the ifmap feeder state encoding and the tagged element pushed through it.
package gin_pkg;

  localparam int VALUE_LEN = 8;
  localparam int ROW_LEN   = 4;
  localparam int ID_LEN    = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } feeder_state_t;

  typedef struct packed {
    logic [ROW_LEN-1:0]   row_tag;
    logic [ID_LEN-1:0]    col_tag;
    logic [VALUE_LEN-1:0] value;
  } tagged_value_t;

endpackage

// File: rtl/ifmap_skid_fifo.sv
// Two-entry FIFO of tagged ifmap elements. The head slot is a register so it
// can drive the GIN enable/tag/value outputs with no logic in between.
module ifmap_skid_fifo
  import gin_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  tagged_value_t din,
  output tagged_value_t head,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  tagged_value_t slot1;
  tagged_value_t head_nxt;
  tagged_value_t slot1_nxt;
  logic [1:0]    count_nxt;
  logic [1:0]    keep;
  logic          do_pop;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    do_pop    = pop && (count != 2'd0);
    keep      = count - {1'b0, do_pop};
    head_nxt  = do_pop ? slot1 : head;
    slot1_nxt = slot1;
    if (push) begin
      if (keep == 2'd0) head_nxt  = din;
      else              slot1_nxt = din;
    end
    count_nxt = keep + {1'b0, push};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      count <= 2'd0;
    end else begin
      head  <= head_nxt;
      count <= count_nxt;
    end
  end

  // NOTE: the second slot is storage, not control; it is never read while
  // the count says it is empty, so it needs no reset.
  always_ff @(posedge clk) begin
    slot1 <= slot1_nxt;
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/ifmap_tag_feeder.sv
// Scans an ifmap tile column-major out of the global buffer SRAM, tags each
// element with (r / rows_per_tag, r % rows_per_tag) and feeds the GIN.
module ifmap_tag_feeder
  import gin_pkg::*;
#(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     num_rows,
  input  logic [DIM_W-1:0]     num_cols,
  input  logic [ID_LEN-1:0]    rows_per_tag,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 sram_re,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [VALUE_LEN-1:0] sram_rdata,
  output logic                 enable,
  input  logic                 ready,
  output logic [ROW_LEN-1:0]   row_tag,
  output logic [ID_LEN-1:0]    col_tag,
  output logic [VALUE_LEN-1:0] value
);

  feeder_state_t state, state_nxt;

  logic [DIM_W-1:0]   cfg_rows, cfg_cols, rd_r, rd_c;
  logic [ID_LEN-1:0]  cfg_rpt, tag_col, pend_col;
  logic [ROW_LEN-1:0] tag_row, pend_row;
  logic [ADDR_W-1:0]  addr, col_addr;
  logic               rd_pend;

  tagged_value_t fifo_head;
  logic          push, pop, full, empty;
  logic [1:0]    count;
  logic [2:0]    occ;
  logic          last_row, last_col, zero_dim;

  assign zero_dim = (num_rows == '0) || (num_cols == '0);
  assign last_row = (rd_r == cfg_rows - DIM_W'(1));
  assign last_col = (rd_c == cfg_cols - DIM_W'(1));

  // Slots already committed next cycle: stored + returning - leaving now.
  assign pop     = !empty && ready;
  assign push    = rd_pend;
  assign occ     = 3'(count) + 3'(rd_pend) - 3'(pop);
  assign sram_re = (state == RUN) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = zero_dim ? FIN : RUN;
      RUN:     if (sram_re && last_row && last_col) state_nxt = DRAIN;
      DRAIN:   if (empty && !rd_pend) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rows <= '0;
      cfg_cols <= '0;
      cfg_rpt  <= '0;
      rd_r     <= '0;
      rd_c     <= '0;
      addr     <= '0;
      col_addr <= '0;
      tag_row  <= '0;
      tag_col  <= '0;
      pend_row <= '0;
      pend_col <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= sram_re;
      if (state == IDLE && start) begin
        cfg_rows <= num_rows;
        cfg_cols <= num_cols;
        cfg_rpt  <= (rows_per_tag == '0) ? ID_LEN'(1) : rows_per_tag;
        rd_r     <= '0;
        rd_c     <= '0;
        addr     <= base_addr;
        col_addr <= base_addr;
        tag_row  <= '0;
        tag_col  <= '0;
      end else if (sram_re) begin
        // Tags ride alongside the read and meet its data one cycle later.
        pend_row <= tag_row;
        pend_col <= tag_col;
        if (last_row) begin
          rd_r     <= '0;
          rd_c     <= rd_c + DIM_W'(1);
          col_addr <= col_addr + ADDR_W'(1);
          addr     <= col_addr + ADDR_W'(1);
          tag_row  <= '0;
          tag_col  <= '0;
        end else begin
          rd_r <= rd_r + DIM_W'(1);
          addr <= addr + ADDR_W'(cfg_cols);
          if (tag_col == cfg_rpt - ID_LEN'(1)) begin
            tag_col <= '0;
            tag_row <= tag_row + ROW_LEN'(1);
          end else begin
            tag_col <= tag_col + ID_LEN'(1);
          end
        end
      end
    end
  end

  ifmap_skid_fifo u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ('{row_tag: pend_row, col_tag: pend_col, value: sram_rdata}),
    .head  (fifo_head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == FIN);
  assign sram_addr = addr;
  assign enable    = !empty;
  assign row_tag   = fifo_head.row_tag;
  assign col_tag   = fifo_head.col_tag;
  assign value     = fifo_head.value;

endmodule

// File: tb/tb_ifmap_tag_feeder.sv
// Self-checking bench for ifmap_tag_feeder: a queue of expected (tags, value)
// tuples built from nested row/column loops is compared against every transfer.
module tb_ifmap_tag_feeder;

  localparam int DIM_W  = 8;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk, rst, start, busy, done, sram_re, enable, ready;
  logic [DIM_W-1:0]  num_rows, num_cols;
  logic [4:0]        rows_per_tag;
  logic [ADDR_W-1:0] base_addr, sram_addr;
  logic [7:0]        sram_rdata, value;
  logic [3:0]        row_tag;
  logic [4:0]        col_tag;

  ifmap_tag_feeder #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_rows     (num_rows),
    .num_cols     (num_cols),
    .rows_per_tag (rows_per_tag),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .sram_re      (sram_re),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .enable       (enable),
    .ready        (ready),
    .row_tag      (row_tag),
    .col_tag      (col_tag),
    .value        (value)
  );

  typedef struct {
    int rt;
    int ct;
    int v;
  } exp_t;

  logic [7:0] mem [DEPTH];
  exp_t       exp_q[$];

  int  checks, failures;
  int  cyc, xfer_n, done_n, re_n, en_n, first_cyc, last_cyc;
  int  cap_rt, cap_ct, cap_v;
  bit  rand_ready, hold;
  logic [31:0] h_rt, h_ct, h_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_re) sram_rdata <= mem[sram_addr];
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) ready = ($urandom_range(0, 99) < 40);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void build_model(input int rows, input int cols, input int rpt, input int base);
    int   g;
    exp_t e;
    g = (rpt == 0) ? 1 : rpt;
    exp_q.delete();
    for (int c = 0; c < cols; c++) begin
      for (int r = 0; r < rows; r++) begin
        e.rt = (r / g) % 16;
        e.ct = r % g;
        e.v  = int'(mem[(base + r * cols + c) % DEPTH]);
        exp_q.push_back(e);
      end
    end
  endfunction

  // One compare process: stability under backpressure and every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_enable", 32'(enable), 32'd1);
        check("hold_row_tag", 32'(row_tag), h_rt);
        check("hold_col_tag", 32'(col_tag), h_ct);
        check("hold_value", 32'(value), h_v);
      end
      if (enable && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 32'(xfer_n), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("xfer_row_tag", 32'(row_tag), 32'(e.rt));
          check("xfer_col_tag", 32'(col_tag), 32'(e.ct));
          check("xfer_value", 32'(value), 32'(e.v));
        end
        if (xfer_n == 465) begin
          cap_rt = int'(row_tag);
          cap_ct = int'(col_tag);
          cap_v  = int'(value);
        end
        if (xfer_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_n++;
      end
      hold = enable && !ready;
      h_rt = 32'(row_tag);
      h_ct = 32'(col_tag);
      h_v  = 32'(value);
      if (done)    done_n++;
      if (sram_re) re_n++;
      if (enable)  en_n++;
    end
  end

  task automatic run_scan(input int rows, input int cols, input int rpt, input int base,
                          input bit bp, input bit busy_start);
    int  total, budget;
    bit  seen, zero;
    total  = rows * cols;
    zero   = (total == 0);
    budget = total * 20 + 50;
    seen   = 1'b0;
    build_model(rows, cols, rpt, base);
    xfer_n = 0; done_n = 0; re_n = 0; en_n = 0;
    cap_rt = -1; cap_ct = -1; cap_v = -1;
    rand_ready = bp;
    if (!bp) ready = 1'b1;
    num_rows     = DIM_W'(rows);
    num_cols     = DIM_W'(cols);
    rows_per_tag = 5'(rpt);
    base_addr    = ADDR_W'(base);
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    if (zero) begin
      check("zero_done_next_cycle", 32'(done), 32'd1);
      check("zero_not_busy", 32'(busy), 32'd0);
      seen = 1'b1;
    end else begin
      check("busy_after_start", 32'(busy), 32'd1);
      check("no_enable_cycle1", 32'(enable), 32'd0);
      @(negedge clk);
      check("no_enable_cycle2", 32'(enable), 32'd0);
      @(negedge clk);
      check("first_enable_latency", 32'(enable), 32'd1);
    end
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk);
      #1;
      if (busy_start) begin
        start = (k == 3);
        if (k == 3) begin
          num_rows = 8'd7; num_cols = 8'd5; rows_per_tag = 5'd2; base_addr = 14'd999;
        end
      end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_single_cycle", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("transfer_count", 32'(xfer_n), 32'(total));
    check("model_drained", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_n), 32'd1);
    if (zero) begin
      check("zero_no_reads", 32'(re_n), 32'd0);
      check("zero_no_enable", 32'(en_n), 32'd0);
    end else if (!bp) begin
      check("back_to_back", 32'(last_cyc - first_cyc + 1), 32'(total));
    end
    rand_ready = 1'b0;
    ready = 1'b1;
  endtask

  task automatic reset_mid_scan();
    bit hit;
    hit = 1'b0;
    build_model(10, 8, 3, 100);
    xfer_n = 0; done_n = 0;
    rand_ready = 1'b0; ready = 1'b1;
    num_rows = 8'd10; num_cols = 8'd8; rows_per_tag = 5'd3; base_addr = 14'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(posedge clk);
      if (xfer_n >= 50) hit = 1'b1;
    end
    check("reached_transfer_50", 32'(hit), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    done_n = 0;
    @(negedge clk);
    check("abort_enable_low", 32'(enable), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done_later", 32'(done_n), 32'd0);
    @(posedge clk);
    #1;
    run_scan(10, 8, 3, 100, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rand_ready = 1'b0; hold = 1'b0;
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    num_rows = '0; num_cols = '0; rows_per_tag = '0; base_addr = '0;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_enable", 32'(enable), 32'd0);
    check("reset_sram_re", 32'(sram_re), 32'd0);
    check("reset_sram_addr", 32'(sram_addr), 32'd0);
    check("reset_tags_value", {20'd0, row_tag, col_tag, value[2:0]}, 32'd0);
    @(posedge clk);
    #1;

    // Hand-derived anchor points for the model itself.
    build_model(60, 224, 30, 0);
    check("model_pin_row_tag", 32'(exp_q[465].rt), 32'd1);
    check("model_pin_col_tag", 32'(exp_q[465].ct), 32'd15);
    check("model_pin_value", 32'(exp_q[465].v), 32'd103);
    build_model(3, 1, 0, 0);
    check("model_pin_rpt0", 32'(exp_q[2].rt * 100 + exp_q[2].ct), 32'd200);
    build_model(20, 1, 1, 0);
    check("model_pin_row_wrap", 32'(exp_q[17].rt), 32'd1);

    // Full tile, ready tied high; element (45,7) is transfer 7*60+45.
    run_scan(60, 224, 30, 0, 1'b0, 1'b0);
    check("tile_r45_c7_row_tag", 32'(cap_rt), 32'd1);
    check("tile_r45_c7_col_tag", 32'(cap_ct), 32'd15);
    check("tile_r45_c7_value", 32'(cap_v), 32'd103);

    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);

    run_scan(4, 3, 3, 16380, 1'b1, 1'b0);
    run_scan(4, 3, 3, 16380, 1'b0, 1'b0);
    run_scan(0, 5, 4, 10, 1'b0, 1'b0);
    run_scan(6, 0, 4, 10, 1'b0, 1'b0);
    run_scan(1, 1, 7, 321, 1'b0, 1'b0);
    run_scan(3, 2, 0, 2000, 1'b0, 1'b0);
    run_scan(20, 2, 1, 40, 1'b1, 1'b0);
    run_scan(9, 6, 4, 500, 1'b0, 1'b1);
    reset_mid_scan();
    for (int i = 0; i < 4; i++) begin
      run_scan($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(0, 31),
               $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
